// File: rtl/count2421_pkg.sv
// Purpose: shared 2421 (Aiken) digit type, constants and step/legality helpers.
// Latency: combinational helpers only.
// Backpressure: none, pure functions.
package count2421_pkg;

  typedef logic [3:0] digit2421_t;

  localparam digit2421_t D2421_ZERO = 4'b0000;
  localparam digit2421_t D2421_NINE = 4'b1111;

  // Next code up; 9 wraps to 0. Illegal inputs collapse to 0.
  function automatic digit2421_t inc2421(input digit2421_t d);
    case (d)
      4'b0000: return 4'b0001;
      4'b0001: return 4'b0010;
      4'b0010: return 4'b0011;
      4'b0011: return 4'b0100;
      4'b0100: return 4'b1011;
      4'b1011: return 4'b1100;
      4'b1100: return 4'b1101;
      4'b1101: return 4'b1110;
      4'b1110: return 4'b1111;
      default: return D2421_ZERO;
    endcase
  endfunction

  // Next code down; 0 wraps to 9. Illegal inputs collapse to 0.
  function automatic digit2421_t dec2421(input digit2421_t d);
    case (d)
      4'b0000: return 4'b1111;
      4'b0001: return 4'b0000;
      4'b0010: return 4'b0001;
      4'b0011: return 4'b0010;
      4'b0100: return 4'b0011;
      4'b1011: return 4'b0100;
      4'b1100: return 4'b1011;
      4'b1101: return 4'b1100;
      4'b1110: return 4'b1101;
      4'b1111: return 4'b1110;
      default: return D2421_ZERO;
    endcase
  endfunction

  // Codes 0101..1010 are not part of the 2421 alphabet.
  function automatic logic legal2421(input digit2421_t d);
    return !((d >= 4'b0101) && (d <= 4'b1010));
  endfunction

endpackage

// File: rtl/count2421_digit.sv
// Purpose: one 2421 decade cell with load, up/down step and cascade limit flag.
// Latency: 1 cycle from en/ld to q.
// Backpressure: none; en is a single-cycle step request.
module count2421_digit
  import count2421_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic       dir,
  input  logic       ld,
  input  digit2421_t ld_val,
  output digit2421_t q,
  output logic       at_limit
);

  digit2421_t q_q, q_d;

  // Load has priority; illegal load codes are replaced by 0 so q stays legal.
  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = legal2421(ld_val) ? ld_val : D2421_ZERO;
    end else if (en) begin
      q_d = dir ? dec2421(q_q) : inc2421(q_q);
    end
  end

  // Digit state register, cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) q_q <= D2421_ZERO;
    else        q_q <= q_d;
  end

  assign q        = q_q;
  assign at_limit = dir ? (q_q == D2421_ZERO) : (q_q == D2421_NINE);

endmodule

// File: rtl/count2421_multi.sv
// Purpose: NUM_DIGITS-digit 2421 up/down event counter with wrap flag; COUNT2421_LOAD_EN adds parallel load.
// Latency: 1 cycle from sampled step (or load) to out/wrap/load_err.
// Backpressure: none; every sampled step is counted, load overrides step.
module count2421_multi
  import count2421_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int EDGE_MODE  = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    x,
  input  logic                    dir,
`ifdef COUNT2421_LOAD_EN
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic                    load_err,
`endif
  output logic [4*NUM_DIGITS-1:0] out,
  output logic                    wrap
);

  localparam int W = 4 * NUM_DIGITS;

  logic              x_q;
  logic              step;
  logic              ld;
  logic [W-1:0]      ld_val;
  logic [NUM_DIGITS:0]   en_chain;
  logic [NUM_DIGITS-1:0] at_lim;
  logic              wrap_q, wrap_d;

`ifdef COUNT2421_LOAD_EN
  logic load_err_q, load_err_d;

  assign ld     = load;
  assign ld_val = load_val;

  // Flag a load that carries any code outside the 2421 alphabet.
  always_comb begin
    load_err_d = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!legal2421(load_val[4*i +: 4])) load_err_d = load;
    end
  end

  // Load error pulse register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) load_err_q <= 1'b0;
    else        load_err_q <= load_err_d;
  end

  assign load_err = load_err_q;
`else
  assign ld     = 1'b0;
  assign ld_val = '0;
`endif

  // Previous x for rising-edge detection; keeps tracking x even during a load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) x_q <= 1'b0;
    else        x_q <= x;
  end

  assign step = (EDGE_MODE != 0) ? (x & ~x_q) : x;

  // Digit k steps when step is set and every lower digit sits at its limit now.
  assign en_chain[0] = step & ~ld;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    assign en_chain[g+1] = en_chain[g] & at_lim[g];

    count2421_digit u_digit (
      .clock    (clock),
      .reset    (reset),
      .en       (en_chain[g]),
      .dir      (dir),
      .ld       (ld),
      .ld_val   (ld_val[4*g +: 4]),
      .q        (out[4*g +: 4]),
      .at_limit (at_lim[g])
    );
  end

  // Wrap happens when the carry/borrow ripples out of the top digit.
  assign wrap_d = en_chain[NUM_DIGITS];

  // Wrap pulse register, aligned with the wrapped out value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) wrap_q <= 1'b0;
    else        wrap_q <= wrap_d;
  end

  assign wrap = wrap_q;

endmodule

// File: tb/tb_count2421_multi.sv
// Purpose: directed bench for count2421_multi, level mode (u_lvl) and edge mode (u_edg) side by side.
// Latency: checks taken 1ns after each rising clock edge.
// Backpressure: n/a.
module tb_count2421_multi;

  logic       clock;
  logic       reset;
  logic       x_lvl, x_edg, dir;
  logic [7:0] out_lvl, out_edg;
  logic       wrap_lvl, wrap_edg;
`ifdef COUNT2421_LOAD_EN
  logic       load_lvl;
  logic [7:0] load_val_lvl;
  logic       load_err_lvl, load_err_edg;
`endif

  int n_chk = 0;
  int n_err = 0;

  count2421_multi #(.NUM_DIGITS(2), .EDGE_MODE(0)) u_lvl (
    .clock    (clock),
    .reset    (reset),
    .x        (x_lvl),
    .dir      (dir),
`ifdef COUNT2421_LOAD_EN
    .load     (load_lvl),
    .load_val (load_val_lvl),
    .load_err (load_err_lvl),
`endif
    .out      (out_lvl),
    .wrap     (wrap_lvl)
  );

  count2421_multi #(.NUM_DIGITS(2), .EDGE_MODE(1)) u_edg (
    .clock    (clock),
    .reset    (reset),
    .x        (x_edg),
    .dir      (dir),
`ifdef COUNT2421_LOAD_EN
    .load     (1'b0),
    .load_val (8'h00),
    .load_err (load_err_edg),
`endif
    .out      (out_edg),
    .wrap     (wrap_edg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Hand-written 2421 table for a decimal 0..99.
  function automatic logic [7:0] enc(input int n);
    logic [3:0] t [10];
    t[0] = 4'h0; t[1] = 4'h1; t[2] = 4'h2; t[3] = 4'h3; t[4] = 4'h4;
    t[5] = 4'hB; t[6] = 4'hC; t[7] = 4'hD; t[8] = 4'hE; t[9] = 4'hF;
    return {t[(n / 10) % 10], t[n % 10]};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; x_lvl = 1'b0; x_edg = 1'b0; dir = 1'b0;
`ifdef COUNT2421_LOAD_EN
    load_lvl = 1'b0; load_val_lvl = 8'h00;
`endif
    #50;
    check("rst_out_lvl", 32'(out_lvl), 32'h00);
    check("rst_wrap_lvl", 32'(wrap_lvl), 32'h0);
    check("rst_out_edg", 32'(out_edg), 32'h00);
    #2 reset = 1'b1;

    // Idle after reset: nothing moves.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_out", 32'(out_lvl), 32'h00);
      check("idle_wrap", 32'(wrap_lvl), 32'h0);
    end

    // Level mode up count through 99, then wrap to 00.
    x_lvl = 1'b1;
    for (int i = 1; i <= 99; i++) begin
      tick();
      check("up_out", 32'(out_lvl), 32'(enc(i)));
      check("up_wrap", 32'(wrap_lvl), 32'h0);
    end
    check("up_at_99", 32'(out_lvl), 32'hFF);
    tick();
    check("wrap_up_out", 32'(out_lvl), 32'h00);
    check("wrap_up_pulse", 32'(wrap_lvl), 32'h1);
    x_lvl = 1'b0;
    tick();
    check("hold_out", 32'(out_lvl), 32'h00);
    check("wrap_one_cycle", 32'(wrap_lvl), 32'h0);

    // Down from 00 wraps to 99, then 98.
    dir = 1'b1; x_lvl = 1'b1;
    tick();
    check("wrap_dn_out", 32'(out_lvl), 32'hFF);
    check("wrap_dn_pulse", 32'(wrap_lvl), 32'h1);
    tick();
    check("dn_98", 32'(out_lvl), 32'hFE);
    check("dn_98_wrap", 32'(wrap_lvl), 32'h0);
    x_lvl = 1'b0;
    tick();
    check("dn_hold", 32'(out_lvl), 32'hFE);
    // Direction flip takes effect at the next step.
    dir = 1'b0; x_lvl = 1'b1;
    tick();
    check("flip_up_99", 32'(out_lvl), 32'hFF);
    check("flip_wrap", 32'(wrap_lvl), 32'h0);
    x_lvl = 1'b0;
    // Down borrow across a digit: 10 -> 09 checked via 20 -> 19 later is not needed; edge mode follows.

    // Edge mode: long high counts once, re-arm counts again.
    x_edg = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("edge_hold_hi", 32'(out_edg), 32'h01);
    end
    x_edg = 1'b0;
    tick();
    check("edge_low", 32'(out_edg), 32'h01);
    x_edg = 1'b1;
    tick();
    check("edge_second", 32'(out_edg), 32'h02);
    x_edg = 1'b0;
    tick();
    check("edge_wrap", 32'(wrap_edg), 32'h0);

    // Async reset mid-count at 15 (8'h1B).
    reset = 1'b0;
    #1;
    check("arst_clear", 32'(out_lvl), 32'h00);
    reset = 1'b1;
    x_lvl = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check("at_15", 32'(out_lvl), 32'h1B);
    x_lvl = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_out", 32'(out_lvl), 32'h00);
    check("mid_rst_wrap", 32'(wrap_lvl), 32'h0);
    check("mid_rst_edg", 32'(out_edg), 32'h00);
    #1 reset = 1'b1;
    x_lvl = 1'b1;
    tick();
    check("first_after_rst", 32'(out_lvl), 32'h01);
    // Down with borrow across a digit boundary: 10 -> 09.
    for (int i = 0; i < 9; i++) tick();
    check("at_10", 32'(out_lvl), 32'h10);
    dir = 1'b1;
    tick();
    check("borrow_09", 32'(out_lvl), 32'h0F);
    check("borrow_wrap", 32'(wrap_lvl), 32'h0);
    x_lvl = 1'b0; dir = 1'b0;

`ifdef COUNT2421_LOAD_EN
    // Load with illegal upper digit, while x is high (load wins).
    x_lvl = 1'b1; load_lvl = 1'b1; load_val_lvl = 8'h5B;
    tick();
    check("ld_bad_out", 32'(out_lvl), 32'h0B);
    check("ld_bad_err", 32'(load_err_lvl), 32'h1);
    check("ld_bad_wrap", 32'(wrap_lvl), 32'h0);
    x_lvl = 1'b0; load_lvl = 1'b0;
    tick();
    check("ld_err_pulse", 32'(load_err_lvl), 32'h0);
    check("ld_hold", 32'(out_lvl), 32'h0B);
    load_lvl = 1'b1; load_val_lvl = 8'h3E;
    tick();
    check("ld_ok_out", 32'(out_lvl), 32'h3E);
    check("ld_ok_err", 32'(load_err_lvl), 32'h0);
    // Load of 99 then a step wraps.
    load_val_lvl = 8'hFF;
    tick();
    load_lvl = 1'b0; x_lvl = 1'b1;
    tick();
    check("ld_then_wrap", 32'(out_lvl), 32'h00);
    check("ld_then_wrap_p", 32'(wrap_lvl), 32'h1);
    check("edg_no_err", 32'(load_err_edg), 32'h0);
    x_lvl = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
